exception_pc_ctrl: RTL and testbench
====================================

EXCEPTION_PC_CTRL -- requirements
Module: exception_pc_ctrl

Interface
REQ-001 SHALL expose: clk  in  1  single system clock, all state updates on rising edge.
REQ-002 SHALL expose: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL expose: exc_opcode / exc_overflow / exc_div0  in  1 each  exception requests from main control (level, sampled in IDLE).
REQ-004 SHALL expose: rte_req  in  1  return-from-exception request.
REQ-005 SHALL expose: norm_src  in  2  PC-source code from main control; norm_pc_wr  in  1  main-control PC write.
REQ-006 SHALL expose: pc_in  in  32  current PC value (already PC+4 of faulting instruction).
REQ-007 SHALL expose: mem_addr  out  32  byte address of exception vector; mem_rd  out  1  memory read strobe.
REQ-008 SHALL expose: mem_byte_in  in  8  memory read data, valid one cycle after mem_rd.
REQ-009 SHALL expose: epc_wr  out  1  EPC write pulse; epc_data  out  32  value for EPC.
REQ-010 SHALL expose: exc_destiny  out  32  handler address, drives PC-source-mux input 00.
REQ-011 SHALL expose: pc_src_sel  out  2  PC-source-mux selector (00 exception, 01 EPC, 10 ALU, 11 shift-left-2).
REQ-012 SHALL expose: pc_wr  out  1  PC write enable; busy  out  1  stall request to main control.

Function
REQ-013 SHALL implement FSM states IDLE, READ, WAIT, LOAD, RET; encoding free.
REQ-014 IDLE: pc_src_sel = norm_src, pc_wr = norm_pc_wr, busy = 0, mem_rd = 0, epc_wr = 0.
REQ-015 IDLE with any exception request SHALL go to READ next cycle; rte_req alone SHALL go to RET.
REQ-016 Simultaneous requests: priority exc_opcode > exc_overflow > exc_div0 > rte_req; lower ones dropped, not queued.
REQ-017 On acceptance SHALL register vector address: opcode 32'd253, overflow 32'd254, div0 32'd255, and epc_data = pc_in - 4 (mod 2^32; pc_in < 4 wraps).
REQ-018 READ (1 cycle): mem_rd = 1, mem_addr = registered vector, epc_wr = 1, pc_wr = 0, busy = 1; next WAIT.
REQ-019 WAIT (1 cycle): mem_rd = 0, busy = 1, pc_wr = 0; end of cycle capture exc_destiny = {24'b0, mem_byte_in}; next LOAD.
REQ-020 LOAD (1 cycle): pc_src_sel = 00, pc_wr = 1, busy = 1; next IDLE.
REQ-021 RET (1 cycle): pc_src_sel = 01, pc_wr = 1, busy = 1, no memory access, no epc_wr; next IDLE.
REQ-022 Exception latency: request sampled at cycle T -> epc_wr/mem_rd at T+1 -> PC load at T+3; rte: PC load at T+1.
REQ-023 All requests and norm_* inputs ignored while busy = 1; norm_pc_wr never reaches pc_wr outside IDLE.
REQ-024 exc_destiny and epc_data SHALL hold their values until the next accepted exception.
REQ-025 epc_wr and mem_rd SHALL be single-cycle pulses per accepted exception.
REQ-026 mem_addr SHALL be 0 outside READ.

Reset
REQ-027 reset high at a rising edge SHALL force IDLE from any state, aborting an in-flight exception without asserting pc_wr.
REQ-028 Reset values: exc_destiny = 0, epc_data = 0, mem_addr = 0, mem_rd = 0, epc_wr = 0, busy = 0; pc_src_sel/pc_wr follow norm_* (IDLE).
REQ-029 Requests asserted in the reset cycle SHALL be ignored; first acceptance possible in the cycle after reset deasserts.

Verification
REQ-030 exc_overflow=1, pc_in=0x0000_0108, mem_byte_in=0x40 in WAIT -> T+1 mem_addr=254, mem_rd=1, epc_wr=1, epc_data=0x104; T+3 pc_src_sel=00, pc_wr=1, exc_destiny=0x40.
REQ-031 exc_opcode, exc_div0, rte_req all 1 same cycle -> mem_addr=253, no RET visit, busy high exactly 3 cycles.
REQ-032 rte_req=1 in IDLE -> next cycle pc_src_sel=01, pc_wr=1, busy=1, mem_rd=0; following cycle IDLE.
REQ-033 IDLE, norm_src=11, norm_pc_wr=1 -> same cycle pc_src_sel=11, pc_wr=1; during busy with norm_pc_wr=1 -> pc_wr=0 in READ/WAIT.
REQ-034 exc_div0 accepted, reset asserted in WAIT -> next cycle IDLE, busy=0, exc_destiny=0, no pc_src_sel=00 with pc_wr=1.
REQ-035 pc_in=0x0000_0002 with exc_div0 -> epc_data=0xFFFF_FFFE, mem_addr=255.

Source files
------------

// File: rtl/exception_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exception_pc_ctrl
// Function : Exception / return-from-exception PC sequencer. Sits beside the
//            main control unit and takes over the PC-source mux and the PC
//            write enable when an exception is raised. It fetches the handler
//            address byte from a fixed vector location and records the
//            faulting PC for EPC.
// Revision : 1.0 - initial release
// ============================================================================
module exception_pc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic        rte_req,
  input  logic [1:0]  norm_src,
  input  logic        norm_pc_wr,
  input  logic [31:0] pc_in,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_byte_in,
  output logic        epc_wr,
  output logic [31:0] epc_data,
  output logic [31:0] exc_destiny,
  output logic [1:0]  pc_src_sel,
  output logic        pc_wr,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    LOAD = 3'd3,
    RET  = 3'd4
  } state_t;

  // Vector table locations holding the handler address byte of each cause
  localparam logic [31:0] c_vec_opcode   = 32'd253;
  localparam logic [31:0] c_vec_overflow = 32'd254;
  localparam logic [31:0] c_vec_div0     = 32'd255;

  // PC-source mux codes
  localparam logic [1:0] c_src_exc = 2'b00;
  localparam logic [1:0] c_src_epc = 2'b01;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_vec;
  logic [31:0] r_epc;
  logic [31:0] r_dest;
  logic        w_any_exc;
  logic [31:0] w_vec_sel;

  assign w_any_exc = exc_opcode | exc_overflow | exc_div0;

  // Fixed-priority vector pick; lower-priority causes are simply dropped
  always_comb begin
    w_vec_sel = c_vec_div0;
    if (exc_opcode)        w_vec_sel = c_vec_opcode;
    else if (exc_overflow) w_vec_sel = c_vec_overflow;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Exception context: vector and EPC latched on acceptance, handler byte in WAIT
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vec  <= '0;
      r_epc  <= '0;
      r_dest <= '0;
    end else begin
      if (r_state == IDLE && w_any_exc) begin
        r_vec <= w_vec_sel;
        r_epc <= pc_in - 32'd4;   // pc_in is already PC+4; wraps below 4
      end
      if (r_state == WAIT) begin
        r_dest <= {24'b0, mem_byte_in};
      end
    end
  end

  // Next-state and output decode; main control only owns the PC in IDLE
  always_comb begin
    w_next     = r_state;
    mem_addr   = '0;
    mem_rd     = 1'b0;
    epc_wr     = 1'b0;
    pc_src_sel = c_src_exc;
    pc_wr      = 1'b0;
    busy       = 1'b1;
    case (r_state)
      IDLE: begin
        pc_src_sel = norm_src;
        pc_wr      = norm_pc_wr;
        busy       = 1'b0;
        if (w_any_exc)    w_next = READ;
        else if (rte_req) w_next = RET;
      end
      READ: begin
        mem_addr = r_vec;
        mem_rd   = 1'b1;
        epc_wr   = 1'b1;
        w_next   = WAIT;
      end
      WAIT: begin
        w_next = LOAD;
      end
      LOAD: begin
        pc_src_sel = c_src_exc;
        pc_wr      = 1'b1;
        w_next     = IDLE;
      end
      RET: begin
        pc_src_sel = c_src_epc;
        pc_wr      = 1'b1;
        w_next     = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign epc_data    = r_epc;
  assign exc_destiny = r_dest;

endmodule
`default_nettype wire

// File: tb/tb_exception_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_exception_pc_ctrl
// Function : Directed, table-driven bench for exception_pc_ctrl. Each table
//            row is one clock cycle: inputs applied after the rising edge,
//            outputs checked on the falling edge, expected values hand-derived.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exception_pc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_opcode, exc_overflow, exc_div0, rte_req;
  logic [1:0]  norm_src;
  logic        norm_pc_wr;
  logic [31:0] pc_in;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_byte_in;
  logic        epc_wr;
  logic [31:0] epc_data;
  logic [31:0] exc_destiny;
  logic [1:0]  pc_src_sel;
  logic        pc_wr;
  logic        busy;

  int total = 0;
  int bad   = 0;

  exception_pc_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .exc_opcode  (exc_opcode),
    .exc_overflow(exc_overflow),
    .exc_div0    (exc_div0),
    .rte_req     (rte_req),
    .norm_src    (norm_src),
    .norm_pc_wr  (norm_pc_wr),
    .pc_in       (pc_in),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_byte_in (mem_byte_in),
    .epc_wr      (epc_wr),
    .epc_data    (epc_data),
    .exc_destiny (exc_destiny),
    .pc_src_sel  (pc_src_sel),
    .pc_wr       (pc_wr),
    .busy        (busy)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, eo, ev, ed, rte;
    logic [1:0]  nsrc;
    logic        npw;
    logic [31:0] pc;
    logic [7:0]  mb;
    logic [31:0] addr;
    logic        rd, ew;
    logic [31:0] epc, dest;
    logic [1:0]  sel;
    logic        chk_sel;   // pc_src_sel is only defined in IDLE/LOAD/RET
    logic        pw, bsy;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=0x%08h want=0x%08h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset        = v.rst;
    exc_opcode   = v.eo;
    exc_overflow = v.ev;
    exc_div0     = v.ed;
    rte_req      = v.rte;
    norm_src     = v.nsrc;
    norm_pc_wr   = v.npw;
    pc_in        = v.pc;
    mem_byte_in  = v.mb;
  endtask

  task automatic check_row(input vec_t v, input int row);
    chk("mem_addr",    row, mem_addr,    v.addr);
    chk("mem_rd",      row, 32'(mem_rd), 32'(v.rd));
    chk("epc_wr",      row, 32'(epc_wr), 32'(v.ew));
    chk("epc_data",    row, epc_data,    v.epc);
    chk("exc_destiny", row, exc_destiny, v.dest);
    if (v.chk_sel) chk("pc_src_sel", row, 32'(pc_src_sel), 32'(v.sel));
    chk("pc_wr",       row, 32'(pc_wr),  32'(v.pw));
    chk("busy",        row, 32'(busy),   32'(v.bsy));
  endtask

  initial begin
    vec_t v;
    //          rst eo ev ed rte nsrc  npw pc           mb     | addr rd ew epc            dest    sel  cs pw bsy
    tbl[0]  = '{1, 1, 0, 0, 0, 2'd2, 0, 32'h0,        8'h00,   32'd0,   0, 0, 32'h0,        32'h0,  2'd2, 1, 0, 0}; // request in reset cycle
    tbl[1]  = '{0, 0, 0, 0, 0, 2'd3, 1, 32'h0,        8'h00,   32'd0,   0, 0, 32'h0,        32'h0,  2'd3, 1, 1, 0}; // IDLE passthrough
    tbl[2]  = '{0, 0, 1, 0, 0, 2'd0, 0, 32'h108,      8'h00,   32'd0,   0, 0, 32'h0,        32'h0,  2'd0, 1, 0, 0}; // overflow, T
    tbl[3]  = '{0, 1, 0, 0, 0, 2'd2, 1, 32'h108,      8'h00,   32'd254, 1, 1, 32'h104,      32'h0,  2'd0, 0, 0, 1}; // READ
    tbl[4]  = '{0, 0, 0, 0, 0, 2'd2, 1, 32'h0,        8'h40,   32'd0,   0, 0, 32'h104,      32'h0,  2'd0, 0, 0, 1}; // WAIT
    tbl[5]  = '{0, 0, 0, 0, 0, 2'd3, 1, 32'h0,        8'h99,   32'd0,   0, 0, 32'h104,      32'h40, 2'd0, 1, 1, 1}; // LOAD
    tbl[6]  = '{0, 1, 0, 1, 1, 2'd1, 0, 32'h200,      8'h00,   32'd0,   0, 0, 32'h104,      32'h40, 2'd1, 1, 0, 0}; // op+div0+rte
    tbl[7]  = '{0, 0, 0, 0, 0, 2'd1, 1, 32'h200,      8'h00,   32'd253, 1, 1, 32'h1FC,      32'h40, 2'd0, 0, 0, 1}; // READ opcode
    tbl[8]  = '{0, 0, 0, 0, 1, 2'd1, 1, 32'h0,        8'h12,   32'd0,   0, 0, 32'h1FC,      32'h40, 2'd0, 0, 0, 1}; // WAIT, rte ignored
    tbl[9]  = '{0, 0, 0, 0, 0, 2'd1, 1, 32'h0,        8'h00,   32'd0,   0, 0, 32'h1FC,      32'h12, 2'd0, 1, 1, 1}; // LOAD
    tbl[10] = '{0, 0, 0, 0, 1, 2'd2, 0, 32'h0,        8'h00,   32'd0,   0, 0, 32'h1FC,      32'h12, 2'd2, 1, 0, 0}; // IDLE, rte
    tbl[11] = '{0, 0, 1, 0, 0, 2'd3, 0, 32'h500,      8'h00,   32'd0,   0, 0, 32'h1FC,      32'h12, 2'd1, 1, 1, 1}; // RET, ovf ignored
    tbl[12] = '{0, 0, 0, 0, 0, 2'd0, 0, 32'h0,        8'h00,   32'd0,   0, 0, 32'h1FC,      32'h12, 2'd0, 1, 0, 0}; // back to IDLE
    tbl[13] = '{0, 0, 0, 1, 0, 2'd0, 0, 32'h2,        8'h00,   32'd0,   0, 0, 32'h1FC,      32'h12, 2'd0, 1, 0, 0}; // div0, pc_in=2
    tbl[14] = '{0, 0, 0, 0, 0, 2'd0, 1, 32'h0,        8'h00,   32'd255, 1, 1, 32'hFFFFFFFE, 32'h12, 2'd0, 0, 0, 1}; // READ, wrapped EPC
    tbl[15] = '{1, 0, 0, 0, 0, 2'd0, 1, 32'h0,        8'h77,   32'd0,   0, 0, 32'hFFFFFFFE, 32'h12, 2'd0, 0, 0, 1}; // WAIT + reset
    tbl[16] = '{0, 0, 0, 0, 0, 2'd0, 0, 32'h0,        8'h00,   32'd0,   0, 0, 32'h0,        32'h0,  2'd0, 1, 0, 0}; // aborted
    tbl[17] = '{0, 0, 0, 0, 0, 2'd3, 1, 32'h0,        8'h00,   32'd0,   0, 0, 32'h0,        32'h0,  2'd3, 1, 1, 0}; // no stray LOAD

    // Initial reset
    v = tbl[0];
    drive(v);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      check_row(tbl[i], i);
      @(posedge clk);
      #1;
    end

    // Abort from READ: opcode accepted, reset during READ
    v = tbl[12];
    drive(v);
    exc_opcode = 1'b1;
    pc_in      = 32'h1000;
    @(posedge clk); #1;
    drive(v);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_read_rd", 100, 32'(mem_rd), 32'd1);
    chk("abort_read_epc", 100, epc_data, 32'hFFC);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 101, 32'(busy), 32'd0);
    chk("abort_epc", 101, epc_data, 32'h0);
    chk("abort_rd", 101, 32'(mem_rd), 32'd0);
    chk("abort_addr", 101, mem_addr, 32'h0);
    // Two more cycles: no late LOAD or RET may drive pc_wr
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_pc_wr", 102 + k, 32'(pc_wr), 32'd0);
      chk("abort_busy2", 102 + k, 32'(busy), 32'd0);
    end

    // Back-to-back: pulses are single-cycle even if the request is held
    exc_div0 = 1'b1;
    pc_in    = 32'h40;
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_rd_t1", 110, 32'(mem_rd), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_rd_t2", 111, 32'(mem_rd), 32'd0);
    chk("hold_ew_t2", 111, 32'(epc_wr), 32'd0);
    exc_div0 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time guard
  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
